// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding selects, load-use stall, branch/jump flush,
// syscall pause/halt sequencing and saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] HALT_V0 = 32'd10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_ra,
    input  logic [4:0]       id_rb,
    input  logic             id_use_ra,
    input  logic             id_use_rb,
    input  logic             id_syscall,
    input  logic [31:0]      syscall_v0,
    input  logic [4:0]       ex_rw,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rw,
    input  logic             mem_regwrite,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             go,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             paused,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, PAUSE, HALT} state_t;
    state_t state_q, state_d;
    logic ex_ok, mem_ok, lu, redir, run, sys_go;
    logic [CNT_W-1:0] cycle_q, jump_q, branch_q, stall_q;

    // loads are excluded from EX forwarding: their data is not ready until MEM
    assign ex_ok  = ex_regwrite & |ex_rw & ~ex_memread;
    assign mem_ok = mem_regwrite & |mem_rw;
    assign lu     = ex_memread & ex_regwrite & |ex_rw &
                    ((id_use_ra & ex_rw == id_ra) | (id_use_rb & ex_rw == id_rb));
    assign redir  = ex_branch_taken | ex_jump;
    assign run    = state_q == RUN;
    assign sys_go = run & id_syscall & ~lu & ~redir;

    assign fwd_a = !rst_n ? 2'b00 : (id_use_ra & ex_ok & ex_rw == id_ra) ? 2'b01 :
                   (id_use_ra & mem_ok & mem_rw == id_ra) ? 2'b10 : 2'b00;
    assign fwd_b = !rst_n ? 2'b00 : (id_use_rb & ex_ok & ex_rw == id_rb) ? 2'b01 :
                   (id_use_rb & mem_ok & mem_rw == id_rb) ? 2'b10 : 2'b00;

    assign paused = rst_n & state_q == PAUSE;
    assign halted = rst_n & state_q == HALT;

    always_comb begin
        state_d    = run ? (sys_go ? (syscall_v0 == HALT_V0 ? HALT : PAUSE) : RUN) :
                     state_q == PAUSE ? (go ? RUN : PAUSE) : HALT;
        pc_en      = rst_n & run & (redir | ~lu);
        ifid_en    = pc_en;
        ifid_flush = !rst_n | (run & redir);
        idex_flush = !rst_n | ~run | redir | lu;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc & ~&v) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q  <= '0;
            jump_q   <= '0;
            branch_q <= '0;
            stall_q  <= '0;
        end else begin
            cycle_q  <= sat_inc(cycle_q, run);
            jump_q   <= sat_inc(jump_q, run & ex_jump);
            branch_q <= sat_inc(branch_q, run & ex_branch_taken);
            stall_q  <= sat_inc(stall_q, run & lu & ~redir);
        end
    end

    assign cycle_cnt  = cycle_q;
    assign jump_cnt   = jump_q;
    assign branch_cnt = branch_q;
    assign stall_cnt  = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of forwarding, hazards, pause/halt and counters.
module tb_pipeline_hazard_ctrl;
    logic clk = 0, rst_n = 0, rst2_n = 0;
    logic [4:0] id_ra, id_rb, ex_rw, mem_rw;
    logic id_use_ra, id_use_rb, id_syscall, ex_regwrite, ex_memread, mem_regwrite;
    logic ex_branch_taken, ex_jump, go;
    logic [31:0] syscall_v0;
    logic [1:0] fwd_a, fwd_b;
    logic pc_en, ifid_en, ifid_flush, idex_flush, paused, halted;
    logic [31:0] cycle_cnt, jump_cnt, branch_cnt, stall_cnt;
    logic [1:0] s_fa, s_fb;
    logic s_pc, s_ie, s_if, s_xf, s_p, s_h;
    logic [3:0] s_cyc, s_j, s_b, s_s;
    int total = 0, bad = 0;
    int e_cyc = 0, e_jmp = 0, e_br = 0, e_stl = 0;
    bit m_run = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_ra(id_ra), .id_rb(id_rb),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_syscall(id_syscall),
        .syscall_v0(syscall_v0), .ex_rw(ex_rw), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rw(mem_rw), .mem_regwrite(mem_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .go(go),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .paused(paused), .halted(halted),
        .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt), .branch_cnt(branch_cnt), .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .id_ra(5'd0), .id_rb(5'd0),
        .id_use_ra(1'b0), .id_use_rb(1'b0), .id_syscall(1'b0),
        .syscall_v0(32'd0), .ex_rw(5'd0), .ex_regwrite(1'b0),
        .ex_memread(1'b0), .mem_rw(5'd0), .mem_regwrite(1'b0),
        .ex_branch_taken(1'b0), .ex_jump(1'b0), .go(1'b0),
        .fwd_a(s_fa), .fwd_b(s_fb), .pc_en(s_pc), .ifid_en(s_ie),
        .ifid_flush(s_if), .idex_flush(s_xf), .paused(s_p), .halted(s_h),
        .cycle_cnt(s_cyc), .jump_cnt(s_j), .branch_cnt(s_b), .stall_cnt(s_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (m_run && rst_n) e_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {id_ra, id_rb, ex_rw, mem_rw} = '0;
        {id_use_ra, id_use_rb, id_syscall, ex_regwrite, ex_memread, mem_regwrite} = '0;
        {ex_branch_taken, ex_jump, go} = '0;
        syscall_v0 = '0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".cyc"}, cycle_cnt, e_cyc);
        check({tag, ".jmp"}, jump_cnt, e_jmp);
        check({tag, ".br"}, branch_cnt, e_br);
        check({tag, ".stl"}, stall_cnt, e_stl);
    endtask

    initial begin
        clear_in();
        ex_rw = 5; mem_rw = 5; ex_regwrite = 1; mem_regwrite = 1;
        id_ra = 5; id_use_ra = 1; ex_jump = 1; id_syscall = 1; go = 1;
        #1;
        check("rst.pc_en", pc_en, 0);
        check("rst.ifid_en", ifid_en, 0);
        check("rst.ifid_flush", ifid_flush, 1);
        check("rst.idex_flush", idex_flush, 1);
        check("rst.fwd_a", fwd_a, 0);
        tick(); tick();
        check("rst.paused", paused, 0);
        check("rst.halted", halted, 0);
        check_cnts("rst");
        clear_in();
        rst_n = 1; m_run = 1;
        #1;
        check("run.pc_en", pc_en, 1);
        check("run.idex_flush", idex_flush, 0);

        ex_rw = 5; mem_rw = 5; ex_regwrite = 1; mem_regwrite = 1; id_ra = 5; id_use_ra = 1;
        #1 check("fwd.ex_prio", fwd_a, 2'b01);
        check("fwd.b_unused", fwd_b, 2'b00);
        ex_regwrite = 0;
        #1 check("fwd.mem", fwd_a, 2'b10);
        ex_regwrite = 1; ex_rw = 0; mem_rw = 0; id_ra = 0;
        #1 check("fwd.r0", fwd_a, 2'b00);
        ex_rw = 5; mem_rw = 5; id_ra = 5; ex_memread = 1;
        #1 check("fwd.load_to_mem", fwd_a, 2'b10);
        check("fwd.load_stall", pc_en, 0);
        clear_in();
        ex_rw = 7; ex_regwrite = 1; id_rb = 7; id_use_rb = 1;
        #1 check("fwd.b_ex", fwd_b, 2'b01);
        id_use_rb = 0;
        #1 check("fwd.b_nouse", fwd_b, 2'b00);
        clear_in();

        ex_memread = 1; ex_regwrite = 1; ex_rw = 8; id_rb = 8; id_use_rb = 1;
        #1;
        check("lu.pc_en", pc_en, 0);
        check("lu.ifid_en", ifid_en, 0);
        check("lu.idex_flush", idex_flush, 1);
        check("lu.ifid_flush", ifid_flush, 0);
        e_stl++;
        tick();
        ex_memread = 0; ex_regwrite = 0;
        #1 check("lu.released", pc_en, 1);
        check_cnts("lu");

        ex_memread = 1; ex_regwrite = 1; ex_jump = 1;
        #1;
        check("lujmp.ifid_flush", ifid_flush, 1);
        check("lujmp.idex_flush", idex_flush, 1);
        check("lujmp.pc_en", pc_en, 1);
        e_jmp++;
        tick();
        clear_in();
        check_cnts("lujmp");

        ex_jump = 1; ex_branch_taken = 1;
        e_jmp++; e_br++;
        tick();
        clear_in();
        check_cnts("brjmp");

        id_syscall = 1; syscall_v0 = 1; ex_jump = 1;
        e_jmp++;
        tick();
        clear_in();
        check("sys_redir.paused", paused, 0);

        id_syscall = 1; syscall_v0 = 1;
        #1 check("sys.pc_en", pc_en, 1);
        tick();
        m_run = 0;
        clear_in();
        check("pause.paused", paused, 1);
        check("pause.halted", halted, 0);
        check("pause.pc_en", pc_en, 0);
        check("pause.ifid_flush", ifid_flush, 0);
        check("pause.idex_flush", idex_flush, 1);
        ex_jump = 1; ex_rw = 3; ex_regwrite = 1; id_ra = 3; id_use_ra = 1;
        #1 check("pause.fwd_a", fwd_a, 2'b01);
        repeat (20) tick();
        clear_in();
        check("pause.held", paused, 1);
        check_cnts("pause");
        go = 1;
        tick();
        m_run = 1;
        go = 0;
        #1;
        check("resume.paused", paused, 0);
        check("resume.pc_en", pc_en, 1);
        tick();
        check_cnts("resume");

        id_syscall = 1; syscall_v0 = 10;
        tick();
        m_run = 0;
        clear_in();
        check("halt.halted", halted, 1);
        check("halt.paused", paused, 0);
        check("halt.pc_en", pc_en, 0);
        go = 1;
        repeat (3) tick();
        go = 0;
        check("halt.go_ignored", halted, 1);
        check_cnts("halt");

        rst_n = 0;
        #1 check("halt_rst.pc_en", pc_en, 0);
        check("halt_rst.ifid_flush", ifid_flush, 1);
        check("halt_rst.halted", halted, 0);
        tick();
        e_cyc = 0; e_jmp = 0; e_br = 0; e_stl = 0;
        rst_n = 1; m_run = 1;
        #1;
        check("postrst.halted", halted, 0);
        check("postrst.pc_en", pc_en, 1);
        check_cnts("postrst");
        tick();
        check("postrst.cyc_runs", cycle_cnt, e_cyc);

        @(posedge clk); #1;
        rst2_n = 1;
        repeat (20) @(posedge clk);
        #1 check("sat.cyc15", s_cyc, 4'd15);
        repeat (3) @(posedge clk);
        #1 check("sat.nowrap", s_cyc, 4'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage redirect (forwarding) MIPS pipeline.
- Produces operand-forwarding selects for the ID/EX operands.
- Detects load-use hazards and stalls; flushes on taken branches and jumps.
- Runs the syscall pause/halt state machine.
- Keeps the performance counters shown on the board display.
- Sits beside the instruction decoder and consumes its RA/RB/RW fields plus pipeline-register control bits.

Parameters:
CNT_W, 32, width of every performance counter
HALT_V0, 10, $v0 value that makes a syscall terminate the program

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset
id_ra  in  5  source register A of instruction in ID (decoder RA)
id_rb  in  5  source register B of instruction in ID (decoder RB)
id_use_ra  in  1  ID instruction actually reads RA
id_use_rb  in  1  ID instruction actually reads RB
id_syscall  in  1  ID instruction is syscall
syscall_v0  in  32  forwarded $v0 value for the ID syscall
ex_rw  in  5  destination register of instruction in EX
ex_regwrite  in  1  EX instruction writes the register file
ex_memread  in  1  EX instruction is a load
mem_rw  in  5  destination register of instruction in MEM
mem_regwrite  in  1  MEM instruction writes the register file
ex_branch_taken  in  1  conditional branch in EX resolved taken
ex_jump  in  1  j/jal/jr in EX
go  in  1  resume request from the board button (level)
fwd_a  out  2  operand A select: 00 regfile, 01 EX result, 10 MEM result
fwd_b  out  2  operand B select, same encoding
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID register write enable
ifid_flush  out  1  clear IF/ID to NOP
idex_flush  out  1  clear ID/EX to NOP (bubble)
paused  out  1  FSM in PAUSE
halted  out  1  FSM in HALT
cycle_cnt  out  CNT_W  cycles spent in RUN
jump_cnt  out  CNT_W  unconditional jumps executed
branch_cnt  out  CNT_W  conditional branches taken
stall_cnt  out  CNT_W  load-use stall cycles

Behaviour:
Clock and reset:
- Single clock; reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- While rst_n=0:
  - FSM goes to RUN; all counters clear to 0; paused=0; halted=0.
  - Combinational outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, fwd_a=fwd_b=00.
- A reset asserted in PAUSE or HALT returns the block to RUN on the next edge.

Forwarding (combinational):
- hitEX(r) = ex_regwrite & ex_rw!=0 & ex_rw==r & !ex_memread.
- hitMEM(r) = mem_regwrite & mem_rw!=0 & mem_rw==r.
- fwd_a = 01 if id_use_ra & hitEX(id_ra); else 10 if id_use_ra & hitMEM(id_ra); else 00. EX has priority over MEM.
- fwd_b is identical using id_rb and id_use_rb.

Load-use stall (combinational):
- lu = ex_memread & ex_regwrite & ex_rw!=0 & ((id_use_ra & ex_rw==id_ra) | (id_use_rb & ex_rw==id_rb)).

Redirect:
- redir = ex_branch_taken | ex_jump.

Output priority in RUN (highest first):
1. redir: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Any lu is ignored because the ID instruction is squashed.
2. lu: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0. The stall lasts exactly 1 cycle per load.
3. Otherwise: pc_en=1, ifid_en=1, no flushes.

FSM states: RUN, PAUSE, HALT (2-bit register).
- RUN -> HALT: id_syscall & !lu & !redir & syscall_v0==HALT_V0. The syscall advances into EX that cycle.
- RUN -> PAUSE: same condition with syscall_v0!=HALT_V0.
- A syscall during lu or redir causes no transition. Under redir it is squashed; under lu it is re-evaluated next cycle.
- In PAUSE: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1, paused=1. Older instructions drain; the instruction in IF/ID is held.
- PAUSE -> RUN: on go=1. The first RUN cycle is the cycle after go is sampled.
- In HALT: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1, halted=1. HALT is terminal until reset; go is ignored.
- In PAUSE and HALT, fwd selects still follow the formulas above.

Counters (registered, update on clk edge, each saturates at all-ones, never wraps):
- cycle_cnt: +1 on every cycle with state RUN.
- jump_cnt: +1 when state==RUN & ex_jump.
- branch_cnt: +1 when state==RUN & ex_branch_taken.
- stall_cnt: +1 when state==RUN & lu & !redir.
- ex_jump and ex_branch_taken asserted together: both count.
- Counters are frozen in PAUSE and HALT.

Test Plan:
- Forwarding priority: ex_rw=mem_rw=5, both regwrite=1, id_ra=5, id_use_ra=1 -> fwd_a=01. Then ex_regwrite=0 -> fwd_a=10. Then ex_rw=mem_rw=0 -> fwd_a=00.
- Load-use: ex_memread=1, ex_rw=8, id_rb=8, id_use_rb=1 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1. The same inputs with ex_jump=1 instead give ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged, jump_cnt +1.
- Pause: id_syscall=1, syscall_v0=1 -> next cycle paused=1, pc_en=0, cycle_cnt frozen for 20 cycles. go=1 -> RUN next cycle, cycle_cnt resumes from its prior value.
- Halt: id_syscall=1, syscall_v0=10 -> halted=1 next cycle. go=1 pulses leave it halted. rst_n=0 for 1 edge -> RUN, all counters 0.
- Saturation: CNT_W=4, run 20 RUN cycles -> cycle_cnt=15 held, no wrap.
- Reset outputs: hold rst_n=0 with arbitrary inputs -> pc_en=0, ifid_en=0, both flushes=1, fwd selects 00, all counters 0.
